fpu_share_arbiter: RTL and testbench

Round-robin arbiter and two-stage issue/result pipeline that shares one combinational half-precision `fpu` among `NUM_REQ` PE-side requesters. It registers the winning request's operands into the shared `fpu`, then captures the result and exception flags into a response register. It returns each response to the originating requester through a valid/ready handshake. It sits in the PE between the graph-update logic (requesters) and the single `fpu` instance.

---
 rtl/fpu_share_arbiter.sv | 131 +++++++++++++
 tb/tb_fpu_share_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// Round-robin share of one combinational fp16 fpu among NUM_REQ requesters.
// S1 registers the winning operands into the fpu; S2 captures the result for the response handshake.
module fpu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_opA,
  input  logic [16*NUM_REQ-1:0]  req_opB,
  input  logic [2*NUM_REQ-1:0]   req_op,
  output logic [15:0]            fpu_opA,
  output logic [15:0]            fpu_opB,
  output logic [1:0]             fpu_op,
  input  logic [15:0]            fpu_result,
  input  logic                   fpu_overflow,
  input  logic                   fpu_underflow,
  input  logic                   fpu_inexact,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [15:0]            resp_result,
  output logic [2:0]             resp_flags,
  output logic                   busy,
  output logic [15:0]            op_count
);

  logic [15:0]     opa_arr [NUM_REQ];
  logic [15:0]     opb_arr [NUM_REQ];
  logic [1:0]      op_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign opa_arr[g] = req_opA[16*g +: 16];
    assign opb_arr[g] = req_opB[16*g +: 16];
    assign op_arr[g]  = req_op[2*g +: 2];
  end

  logic            s1_valid;
  logic [ID_W-1:0] s1_tag;
  logic [15:0]     s1_opa;
  logic [15:0]     s1_opb;
  logic [1:0]      s1_op;

  logic            s2_valid;
  logic [ID_W-1:0] s2_tag;
  logic [15:0]     s2_result;
  logic [2:0]      s2_flags;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] idx;
  logic            grant_found;
  logic            s2_drain;
  logic            s2_free;
  logic            s1_free;
  logic            advance;
  logic            accept;

  // First valid requester at or after ptr, wrapping mod NUM_REQ.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  assign s2_drain = s2_valid & resp_ready[s2_tag];
  assign s2_free  = !s2_valid | s2_drain;
  assign s1_free  = !s1_valid | s2_free;
  assign advance  = s1_valid & s2_free;
  assign accept   = grant_found & s1_free & !reset;

  assign req_ready   = accept ? (NUM_REQ'(1) << grant) : '0;
  assign resp_valid  = s2_valid ? (NUM_REQ'(1) << s2_tag) : '0;
  assign resp_result = s2_result;
  assign resp_flags  = s2_flags;
  assign busy        = s1_valid | s2_valid;

  // S1 fields only change on accept, so the fpu inputs stay quiet while idle.
  assign fpu_opA = s1_opa;
  assign fpu_opB = s1_opb;
  assign fpu_op  = s1_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      s1_opa    <= '0;
      s1_opb    <= '0;
      s1_op     <= '0;
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
      s2_result <= '0;
      s2_flags  <= '0;
      ptr       <= '0;
      op_count  <= '0;
    end else begin
      if (advance) begin
        s2_valid  <= 1'b1;
        s2_tag    <= s1_tag;
        s2_result <= fpu_result;
        s2_flags  <= {fpu_overflow, fpu_underflow, fpu_inexact};
      end else if (s2_drain) begin
        s2_valid <= 1'b0;
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_tag   <= grant;
        s1_opa   <= opa_arr[grant];
        s1_opb   <= opb_arr[grant];
        s1_op    <= op_arr[grant];
        ptr      <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (s2_drain) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Self-checking bench for fpu_share_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based model of the shared pipeline.
module tb_fpu_share_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [16*N-1:0]   req_opA;
  logic [16*N-1:0]   req_opB;
  logic [2*N-1:0]    req_op;
  logic [15:0]       fpu_opA;
  logic [15:0]       fpu_opB;
  logic [1:0]        fpu_op;
  logic [15:0]       fpu_result;
  logic              fpu_overflow;
  logic              fpu_underflow;
  logic              fpu_inexact;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [15:0]       resp_result;
  logic [2:0]        resp_flags;
  logic              busy;
  logic [15:0]       op_count;

  int n_checks = 0;
  int n_pass   = 0;

  fpu_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opA      (req_opA),
    .req_opB      (req_opB),
    .req_op       (req_op),
    .fpu_opA      (fpu_opA),
    .fpu_opB      (fpu_opB),
    .fpu_op       (fpu_op),
    .fpu_result   (fpu_result),
    .fpu_overflow (fpu_overflow),
    .fpu_underflow(fpu_underflow),
    .fpu_inexact  (fpu_inexact),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_flags   (resp_flags),
    .busy         (busy),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  // Stand-in fpu: returns {result, overflow, underflow, inexact}.
  function automatic logic [18:0] fake_fpu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
    logic [15:0] r;
    if (a == 16'h3C00 && b == 16'h4000 && op == 2'b00) r = 16'h4200;
    else r = a + b + {14'd0, op};
    return {r, r[14:10] == 5'h1F, r[14:10] == 5'h00, a[0] | b[0]};
  endfunction

  always_comb {fpu_result, fpu_overflow, fpu_underflow, fpu_inexact} =
      fake_fpu(fpu_opA, fpu_opB, fpu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Model: ordered list of in-flight ops; at_out marks the one presented as a response.
  typedef struct {
    int          tag;
    logic [15:0] res;
    logic [2:0]  fl;
    bit          at_out;
  } ent_t;

  ent_t        q[$];
  int          m_ptr   = 0;
  logic [15:0] m_count = '0;
  logic [15:0] m_a     = '0;
  logic [15:0] m_b     = '0;
  logic [1:0]  m_op    = '0;

  task automatic model_step();
    bit          out_exists, waiting, out_fire, in_free, found;
    int          g;
    logic [N-1:0] exp_ready, exp_rv;
    logic [18:0] f;
    ent_t        e;
    out_exists = q.size() > 0 && q[0].at_out;
    waiting    = q.size() > 0 && !q[q.size()-1].at_out;
    out_fire   = out_exists && resp_ready[q[0].tag];
    in_free    = !waiting || !out_exists || out_fire;
    found = 0;
    g     = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_valid[(m_ptr + i) % N]) begin
        found = 1;
        g     = (m_ptr + i) % N;
      end
    end
    exp_ready = (found && in_free && !reset) ? N'(1) << g : '0;
    exp_rv    = out_exists ? N'(1) << q[0].tag : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(q.size() > 0));
    check("op_count", 32'(op_count), 32'(m_count));
    check("fpu_opA", 32'(fpu_opA), 32'(m_a));
    if (out_exists) begin
      check("resp_result", 32'(resp_result), 32'(q[0].res));
      check("resp_flags", 32'(resp_flags), 32'(q[0].fl));
    end
    if (reset) begin
      q.delete();
      m_ptr   = 0;
      m_count = '0;
      m_a     = '0;
      m_b     = '0;
      m_op    = '0;
    end else begin
      if (out_fire) begin
        void'(q.pop_front());
        m_count = m_count + 16'd1;
      end
      if (q.size() > 0 && !q[0].at_out) begin
        e        = q[0];
        e.at_out = 1;
        q[0]     = e;
      end
      if (exp_ready != 0) begin
        m_a  = req_opA[16*g +: 16];
        m_b  = req_opB[16*g +: 16];
        m_op = req_op[2*g +: 2];
        f    = fake_fpu(m_a, m_b, m_op);
        q.push_back('{tag: g, res: f[18:3], fl: f[2:0], at_out: 0});
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  // Check at the falling edge, then advance one rising edge; inputs change #1 after it.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_opA[16*i +: 16] = 16'($urandom);
      req_opB[16*i +: 16] = 16'($urandom);
      req_op[2*i +: 2]    = 2'($urandom);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op);
    req_opA[16*i +: 16] = a;
    req_opB[16*i +: 16] = b;
    req_op[2*i +: 2]    = op;
  endtask

  logic [18:0] f1;

  initial begin
    reset      = 1'b1;
    req_valid  = '1;
    resp_ready = '1;
    req_opA    = '0;
    req_opB    = '0;
    req_op     = '0;
    @(posedge clk);
    #1;
    repeat (2) tick();
    check("rst_result", 32'(resp_result), 32'h0);
    check("rst_flags", 32'(resp_flags), 32'h0);
    check("rst_fpu_op", 32'(fpu_op), 32'h0);

    reset = 1'b0;
    rand_ops();
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Single add from requester 2.
    set_req(2, 16'h3C00, 16'h4000, 2'b00);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check("lat1_idle", 32'(resp_valid), 32'h0);
    tick();
    check("lat2_valid", 32'(resp_valid), 32'h4);
    check("lat2_result", 32'(resp_result), 32'h4200);
    check("lat2_flags", 32'(resp_flags), 32'h0);
    tick();
    check("single_count", 32'(op_count), 32'd2);

    // Full streaming, all requesters.
    req_valid = '1;
    repeat (12) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Requester 1 response stalled for 5 cycles while requester 3 waits.
    resp_ready = 4'b1101;
    set_req(1, 16'h1234, 16'h0100, 2'b01);
    f1 = fake_fpu(16'h1234, 16'h0100, 2'b01);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1000;
    set_req(3, 16'h2222, 16'h0011, 2'b10);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_result", 32'(resp_result), 32'(f1[18:3]));
      check("hold_ready", 32'(req_ready), 32'h0);
      check("hold_fpu_opA", 32'(fpu_opA), 32'h2222);
      tick();
    end
    resp_ready = '1;
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Flag passthrough.
    set_req(0, 16'h7BFF, 16'h0001, 2'b00);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check("flag_valid", 32'(resp_valid), 32'h1);
    check("flag_result", 32'(resp_result), 32'h7C00);
    check("flag_flags", 32'(resp_flags), 32'h5);
    tick();

    // Reset with both stages full.
    resp_ready = '0;
    req_valid  = '1;
    rand_ops();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = '0;
    check("mid_rst_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_count", 32'(op_count), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    resp_ready = '1;
    set_req(2, 16'h3C00, 16'h4000, 2'b00);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    check("post_rst_valid", 32'(resp_valid), 32'h4);
    check("post_rst_result", 32'(resp_result), 32'h4200);
    tick();
    check("post_rst_count", 32'(op_count), 32'h1);

    // Random traffic.
    repeat (400) begin
      rand_ops();
      req_valid  = N'($urandom);
      resp_ready = N'($urandom) | N'($urandom);
      tick();
    end
    resp_ready = '1;
    req_valid  = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
